alu_dispatch: RTL and testbench

//  Upstream feeder for the 8-bit ALU: accepts a byte-serial instruction stream, decodes it,

---
 rtl/alu_pkg.sv | 39 +++
 rtl/dispatch_regfile.sv | 38 +++
 rtl/alu_dispatch.sv | 139 +++++++++++++
 tb/tb_alu_dispatch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch path: opcodes, instruction field positions,
// FSM state encoding and the default ALU latency.
package alu_pkg;

  localparam int ALU_LATENCY_DEFAULT = 1;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;

  localparam int IMM_POS = 7;
  localparam int DST_MSB = 6;
  localparam int DST_LSB = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;
  localparam int SRC_MSB = 2;
  localparam int SRC_LSB = 0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPND = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_REJ  = 3'd4;

  function automatic logic opIsLegal(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic opIsDivide(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/dispatch_regfile.sv
// 8x8 register file for the ALU dispatcher: one synchronous write port, two
// combinational operand read ports and a combinational debug read port.
module dispatch_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [2:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [2:0] raddrA_i,
  output logic [7:0] rdataA_o,
  input  logic [2:0] raddrB_i,
  output logic [7:0] rdataB_o,
  input  logic [2:0] dbgAddr_i,
  output logic [7:0] dbgData_o
);

  logic [7:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads are combinational, so a read during the write cycle sees the old value.
  assign rdataA_o  = mem_q[raddrA_i];
  assign rdataB_o  = mem_q[raddrB_i];
  assign dbgData_o = mem_q[dbgAddr_i];

endmodule

// File: rtl/alu_dispatch.sv
// Byte-serial instruction dispatcher feeding the 8-bit ALU: decodes two-byte
// instructions, fetches operands, waits out the ALU latency and writes results back.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = ALU_LATENCY_DEFAULT,
  parameter int NREGS       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] alu_A,
  output logic [7:0] alu_B,
  output logic [7:0] alu_Selector,
  input  logic [7:0] alu_X,
  input  logic [7:0] alu_Flags,
  output logic [7:0] flags_q,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       dst_q, dst_d;
  logic             imm_q, imm_d;
  logic [7:0]       opA_q, opA_d;
  logic [7:0]       opB_q, opB_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       flags_d;

  logic       accept;
  logic [7:0] rdA, rdB, operandB;
  logic       wrEn;
  logic [7:0] wrData;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_OPND);
  assign accept   = in_valid && in_ready;
  assign operandB = imm_q ? in_data : rdB;

  dispatch_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wrEn),
    .waddr_i  (dst_q),
    .wdata_i  (wrData),
    .raddrA_i (dst_q),
    .rdataA_o (rdA),
    .raddrB_i (in_data[SRC_MSB:SRC_LSB]),
    .rdataB_o (rdB),
    .dbgAddr_i(dbg_addr),
    .dbgData_o(dbg_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = in_data[OP_MSB:OP_LSB];
          dst_d   = in_data[DST_MSB:DST_LSB];
          imm_d   = in_data[IMM_POS];
          state_d = ST_OPND;
        end
      end
      ST_OPND: begin
        // Operands are sampled here, so dst==src reads the pre-writeback value.
        if (accept) begin
          opA_d = rdA;
          opB_d = operandB;
          cnt_d = '0;
          if (!opIsLegal(op_q) || (opIsDivide(op_q) && operandB == 8'h00)) begin
            state_d = ST_REJ;
          end else if (op_q == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(ALU_LATENCY - 1)) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_REJ:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wrEn    = (state_q == ST_WB);
  assign wrData  = (op_q == OP_LOAD) ? opB_q : alu_X;
  assign flags_d = (wrEn && op_q != OP_LOAD) ? alu_Flags : flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      imm_q   <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign alu_A        = opA_q;
  assign alu_B        = opB_q;
  assign alu_Selector = (state_q == ST_EXEC) ? {4'b0000, op_q} : 8'h00;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_WB);
  assign err          = (state_q == ST_REJ);

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed vector table, back-to-back stream,
// randomized instructions against a register-level reference model, and reset mid-EXEC.
module tb_alu_dispatch;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] alu_A, alu_B, alu_Selector;
  logic [7:0] alu_X = 8'h00;
  logic [7:0] alu_Flags = 8'h00;
  logic [7:0] flags_q;
  logic       busy, done, err;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] refRegs [8];
  logic [7:0] refFlags;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         expDone;
    bit         expErr;
    int         expCycles;
    logic [7:0] expSel;
    logic [7:0] expDst;
    logic [7:0] expFlags;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  alu_dispatch #(.ALU_LATENCY(1), .NREGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_Selector(alu_Selector),
    .alu_X       (alu_X),
    .alu_Flags   (alu_Flags),
    .flags_q     (flags_q),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: result {flags, X}; flags = {zero, negative, carry/borrow/high-byte, 5'b0}
  function automatic logic [15:0] aluRef(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    logic [7:0]  x;
    w = 16'h0000;
    case (sel)
      8'd1: w = {8'h00, a} + {8'h00, b};
      8'd2: w = {8'h00, a} - {8'h00, b};
      8'd3: w = {8'h00, a} * {8'h00, b};
      8'd4: w = (b != 0) ? {8'h00, a / b} : 16'h0000;
      8'd5: w = (b != 0) ? {8'h00, a % b} : 16'h0000;
      8'd6: w = {8'h00, a & b};
      8'd7: w = {8'h00, a | b};
      8'd8: w = {8'h00, a ^ b};
      default: w = 16'h0000;
    endcase
    x = w[7:0];
    return {(x == 8'h00), x[7], (w[15:8] != 8'h00), 5'b00000, x};
  endfunction

  // Stand-in ALU with one cycle of latency
  always @(posedge clk) begin
    {alu_Flags, alu_X} <= aluRef(alu_Selector, alu_A, alu_B);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out, got no handshake, expected one", name);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) flagTimeout("in_ready");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends one instruction and observes it until the dispatcher is idle again.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               output int cycles, output bit gotDone, output bit gotErr,
                               output logic [7:0] sel, output int selCycles,
                               output logic [7:0] dbgAtDone);
    int n;
    dbg_addr  = b0[6:4];
    sel       = 8'h00;
    selCycles = 0;
    gotDone   = 1'b0;
    gotErr    = 1'b0;
    dbgAtDone = 8'h00;
    sendByte(b0);
    sendByte(b1);
    cycles = 2;
    n = 0;
    while (busy && n < 50) begin
      if (done) begin
        gotDone   = 1'b1;
        dbgAtDone = dbg_data;
      end
      if (err) gotErr = 1'b1;
      if (alu_Selector != 8'h00) begin
        sel = alu_Selector;
        selCycles++;
      end
      @(posedge clk); #1;
      cycles++;
      n++;
    end
    if (busy) flagTimeout("busy");
  endtask

  task automatic runTable();
    int cycles, selCycles;
    bit gotDone, gotErr;
    logic [7:0] sel, dbgAtDone, pre;
    logic [2:0] dst;
    vecs[0]  = '{8'h90, 8'h05, 1, 0, 3, 8'd0, 8'h05, 8'h00};
    vecs[1]  = '{8'hA0, 8'h03, 1, 0, 3, 8'd0, 8'h03, 8'h00};
    vecs[2]  = '{8'h11, 8'h02, 1, 0, 4, 8'd1, 8'h08, 8'h00};
    vecs[3]  = '{8'h90, 8'h05, 1, 0, 3, 8'd0, 8'h05, 8'h00};
    vecs[4]  = '{8'h92, 8'h03, 1, 0, 4, 8'd2, 8'h02, 8'h00};
    vecs[5]  = '{8'h14, 8'h03, 0, 1, 3, 8'd0, 8'h02, 8'h00};
    vecs[6]  = '{8'h19, 8'h55, 0, 1, 3, 8'd0, 8'h02, 8'h00};
    vecs[7]  = '{8'h98, 8'h0F, 1, 0, 4, 8'd8, 8'h0D, 8'h00};
    vecs[8]  = '{8'hC2, 8'h01, 1, 0, 4, 8'd2, 8'hFF, 8'h60};
    vecs[9]  = '{8'h13, 8'h01, 1, 0, 4, 8'd3, 8'hA9, 8'h40};
    vecs[10] = '{8'h94, 8'h00, 0, 1, 3, 8'd0, 8'hA9, 8'h40};
    vecs[11] = '{8'h95, 8'h10, 1, 0, 4, 8'd5, 8'h09, 8'h00};
    vecs[12] = '{8'h46, 8'h01, 1, 0, 4, 8'd6, 8'h09, 8'h00};
    vecs[13] = '{8'hD7, 8'h00, 1, 0, 4, 8'd7, 8'h00, 8'h80};
    for (int i = 0; i < 14; i++) begin
      dst = vecs[i].b0[6:4];
      pre = refRegs[dst];
      applyStimulus(vecs[i].b0, vecs[i].b1, cycles, gotDone, gotErr, sel, selCycles, dbgAtDone);
      checkOutput($sformatf("vec%0d done", i), gotDone, vecs[i].expDone);
      checkOutput($sformatf("vec%0d err", i), gotErr, vecs[i].expErr);
      checkOutput($sformatf("vec%0d cycles", i), cycles, vecs[i].expCycles);
      checkOutput($sformatf("vec%0d selector", i), sel, vecs[i].expSel);
      checkOutput($sformatf("vec%0d selCycles", i), selCycles, (vecs[i].expSel != 0) ? 1 : 0);
      if (vecs[i].expDone) checkOutput($sformatf("vec%0d dbgPreWrite", i), dbgAtDone, pre);
      dbg_addr = dst;
      #1;
      checkOutput($sformatf("vec%0d R%0d", i, dst), dbg_data, vecs[i].expDst);
      checkOutput($sformatf("vec%0d flags", i), flags_q, vecs[i].expFlags);
      refRegs[dst] = vecs[i].expDst;
      refFlags     = vecs[i].expFlags;
    end
  endtask

  // Reference model: applies one instruction to refRegs/refFlags, reports rejection and LOAD.
  task automatic modelInstr(input logic [7:0] b0, input logic [7:0] b1, output bit rej, output bit isLoad);
    logic [3:0]  op;
    logic [2:0]  dst;
    logic [7:0]  a, b;
    logic [15:0] r;
    op     = b0[3:0];
    dst    = b0[6:4];
    a      = refRegs[dst];
    b      = b0[7] ? b1 : refRegs[b1[2:0]];
    isLoad = (op == OP_LOAD);
    rej    = (op > OP_XOR) || ((op == OP_DIV || op == OP_MOD) && b == 8'h00);
    if (!rej) begin
      if (isLoad) begin
        refRegs[dst] = b;
      end else begin
        r = aluRef({4'b0000, op}, a, b);
        refRegs[dst] = r[7:0];
        refFlags     = r[15:8];
      end
    end
  endtask

  task automatic runRandom(input int count);
    int cycles, selCycles;
    bit gotDone, gotErr, rej, isLoad;
    logic [7:0] sel, dbgAtDone, b0, b1;
    for (int i = 0; i < count; i++) begin
      b0 = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 11))};
      b1 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      modelInstr(b0, b1, rej, isLoad);
      applyStimulus(b0, b1, cycles, gotDone, gotErr, sel, selCycles, dbgAtDone);
      checkOutput($sformatf("rnd%0d done", i), gotDone, !rej);
      checkOutput($sformatf("rnd%0d err", i), gotErr, rej);
      checkOutput($sformatf("rnd%0d cycles", i), cycles, (rej || isLoad) ? 3 : 4);
      dbg_addr = b0[6:4];
      #1;
      checkOutput($sformatf("rnd%0d R%0d", i, b0[6:4]), dbg_data, refRegs[b0[6:4]]);
      checkOutput($sformatf("rnd%0d flags", i), flags_q, refFlags);
    end
  endtask

  task automatic runBackToBack();
    int cycles, selCycles, idx, doneCnt;
    int accEdge [6];
    bit gotDone, gotErr, take, rej, isLoad;
    logic [7:0] sel, dbgAtDone;
    logic [7:0] bb [6];
    modelInstr(8'h90, 8'h01, rej, isLoad);
    applyStimulus(8'h90, 8'h01, cycles, gotDone, gotErr, sel, selCycles, dbgAtDone);
    modelInstr(8'hA0, 8'h02, rej, isLoad);
    applyStimulus(8'hA0, 8'h02, cycles, gotDone, gotErr, sel, selCycles, dbgAtDone);
    for (int k = 0; k < 6; k++) begin
      bb[k]      = (k % 2 == 0) ? 8'h11 : 8'h02;
      accEdge[k] = 0;
    end
    for (int k = 0; k < 3; k++) modelInstr(8'h11, 8'h02, rej, isLoad);
    idx      = 0;
    doneCnt  = 0;
    dbg_addr = 3'd1;
    in_valid = 1'b1;
    in_data  = bb[0];
    for (int cyc = 1; cyc <= 16; cyc++) begin
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        accEdge[idx] = cyc;
        idx++;
        if (idx < 6) in_data = bb[idx];
        else in_valid = 1'b0;
      end
      if (done) doneCnt++;
    end
    in_valid = 1'b0;
    checkOutput("b2b bytesAccepted", idx, 6);
    checkOutput("b2b doneCount", doneCnt, 3);
    checkOutput("b2b operandGap", accEdge[1] - accEdge[0], 1);
    checkOutput("b2b instrSpacing1", accEdge[2] - accEdge[0], 4);
    checkOutput("b2b instrSpacing2", accEdge[4] - accEdge[2], 4);
    checkOutput("b2b R1", dbg_data, refRegs[1]);
    checkOutput("b2b flags", flags_q, refFlags);
  endtask

  task automatic runResetInExec();
    int cycles, selCycles, doneCnt;
    bit gotDone, gotErr, rej, isLoad;
    logic [7:0] sel, dbgAtDone;
    modelInstr(8'h90, 8'h33, rej, isLoad);
    applyStimulus(8'h90, 8'h33, cycles, gotDone, gotErr, sel, selCycles, dbgAtDone);
    dbg_addr = 3'd1;
    sendByte(8'h91);
    sendByte(8'h01);
    checkOutput("rstExec selectorBefore", alu_Selector, 8'd1);
    checkOutput("rstExec busyBefore", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstExec busy", busy, 1'b0);
    checkOutput("rstExec in_ready", in_ready, 1'b1);
    checkOutput("rstExec done", done, 1'b0);
    checkOutput("rstExec selector", alu_Selector, 8'h00);
    checkOutput("rstExec alu_A", alu_A, 8'h00);
    checkOutput("rstExec flags", flags_q, 8'h00);
    checkOutput("rstExec R1", dbg_data, 8'h00);
    doneCnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkOutput("rstExec noLateDone", doneCnt, 0);
    checkOutput("rstExec R1After", dbg_data, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) refRegs[i] = 8'h00;
    refFlags = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset selector", alu_Selector, 8'h00);
    checkOutput("reset alu_A", alu_A, 8'h00);
    checkOutput("reset alu_B", alu_B, 8'h00);
    checkOutput("reset flags", flags_q, 8'h00);
    checkOutput("reset R0", dbg_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    runTable();
    runBackToBack();
    runRandom(40);
    runResetInExec();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
